// File: rtl/fpu_pkg.sv
// Shared FPU result definitions: status codes, field widths and the
// packed result-word layout used by the result monitor.
package fpu_pkg;

   localparam int FPU_W  = 32;
   localparam int EXP_W  = 6;
   localparam int MANT_W = 25;
   localparam int ST_W   = 4;

   localparam logic [ST_W-1:0] ST_NONE      = 4'b0000;
   localparam logic [ST_W-1:0] ST_EXACT     = 4'b0001;
   localparam logic [ST_W-1:0] ST_OVERFLOW  = 4'b0100;
   localparam logic [ST_W-1:0] ST_UNDERFLOW = 4'b1000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fpu_word_t;

   // One FIFO entry / capture word: status in the top nibble, result below.
   typedef struct packed {
      logic [ST_W-1:0] status;
      fpu_word_t       word;
   } fpu_entry_t;

endpackage

// File: rtl/fpu_mon_fifo.sv
// Generic show-ahead FIFO. The head is read combinationally from storage;
// while empty the output holds the last popped entry. Full/empty come from
// the occupancy counter, so pointers only need log2(DEPTH) bits.
module fpu_mon_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] last_pop_q;
   logic             push_fire, pop_fire;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
   assign pop_fire  = pop_i && !empty_o;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_fire = push_i && (!full_o || pop_fire);
   assign count_o   = count_q;
   assign data_o    = empty_o ? last_pop_q : mem_q[rd_ptr_q];

   // Occupancy next-state: +1 push only, -1 pop only, otherwise unchanged.
   always_comb begin
      // NOTE: default assigned first so every path drives count_d -- no latch.
      count_d = count_q;
      case ({push_fire, pop_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage write at the tail on an accepted push.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; it is only observed through count-gated reads.
      if (push_fire) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers, occupancy and the held last-popped value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_pop_q <= '0;
      end else begin
         count_q <= count_d;
         if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_fire) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            last_pop_q <= mem_q[rd_ptr_q];
         end
      end
   end

endmodule

// File: rtl/fpu_result_monitor.sv
// FPU result monitor: detects each newly published FPU result, queues it
// with its status in a show-ahead FIFO drained by valid/ready, and keeps a
// sticky drop flag for results lost while the FIFO was full.
// Optional statistics counters are enabled by defining FPU_MON_STATS_EN.
module fpu_result_monitor
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4
`ifdef FPU_MON_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic                     clock100KHz,
   input  logic                     reset,
   input  logic [FPU_W-1:0]         data_in,
   input  logic [ST_W-1:0]          status_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FPU_W-1:0]         out_data,
   output logic [ST_W-1:0]          out_status,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     drop_flag,
   input  logic                     clear
`ifdef FPU_MON_STATS_EN
   ,
   output logic [CNT_W-1:0]         cnt_exact,
   output logic [CNT_W-1:0]         cnt_overflow,
   output logic [CNT_W-1:0]         cnt_underflow,
   output logic [CNT_W-1:0]         cnt_drop
`endif
);

   fpu_entry_t in_entry, head_entry, last_word_q;
   logic       new_result, pop_req, refused, full, empty;
   logic       drop_flag_q, drop_flag_d;

   assign in_entry.status = status_in;
   assign in_entry.word   = fpu_word_t'(data_in);

   // The FPU holds its outputs between publications, so only a change of the
   // full {status,result} word (with a nonzero status) marks a new result.
   assign new_result = (status_in != ST_NONE) && (in_entry != last_word_q);
   assign pop_req    = out_valid && out_ready;
   assign refused    = new_result && full && !pop_req;

   fpu_mon_fifo #(
      .WIDTH ($bits(fpu_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clock100KHz),
      .rst_n   (reset),
      .push_i  (new_result),
      .pop_i   (pop_req),
      .data_i  (in_entry),
      .data_o  (head_entry),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fill_level)
   );

   assign out_valid  = !empty;
   assign out_data   = head_entry.word;
   assign out_status = head_entry.status;
   assign drop_flag  = drop_flag_q;

   // Sticky drop flag: a refused push beats a same-cycle clear.
   always_comb begin
      drop_flag_d = drop_flag_q;
      if (refused)    drop_flag_d = 1'b1;
      else if (clear) drop_flag_d = 1'b0;
   end

   // Capture register and drop flag state.
   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         last_word_q <= '0;
         drop_flag_q <= 1'b0;
      end else begin
         if (new_result) last_word_q <= in_entry;
         drop_flag_q <= drop_flag_d;
      end
   end

`ifdef FPU_MON_STATS_EN
   logic [CNT_W-1:0] cnt_exact_q, cnt_overflow_q, cnt_underflow_q, cnt_drop_q;
   logic [CNT_W-1:0] cnt_exact_d, cnt_overflow_d, cnt_underflow_d, cnt_drop_d;

   // Saturating counters: clear first, then an event in the same cycle still counts.
   always_comb begin
      cnt_exact_d     = clear ? '0 : cnt_exact_q;
      cnt_overflow_d  = clear ? '0 : cnt_overflow_q;
      cnt_underflow_d = clear ? '0 : cnt_underflow_q;
      cnt_drop_d      = clear ? '0 : cnt_drop_q;
      if (new_result && status_in == ST_EXACT && cnt_exact_d != '1)
         cnt_exact_d = cnt_exact_d + 1'b1;
      if (new_result && status_in == ST_OVERFLOW && cnt_overflow_d != '1)
         cnt_overflow_d = cnt_overflow_d + 1'b1;
      if (new_result && status_in == ST_UNDERFLOW && cnt_underflow_d != '1)
         cnt_underflow_d = cnt_underflow_d + 1'b1;
      if (refused && cnt_drop_d != '1)
         cnt_drop_d = cnt_drop_d + 1'b1;
   end

   // Statistics counter registers.
   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         cnt_exact_q     <= '0;
         cnt_overflow_q  <= '0;
         cnt_underflow_q <= '0;
         cnt_drop_q      <= '0;
      end else begin
         cnt_exact_q     <= cnt_exact_d;
         cnt_overflow_q  <= cnt_overflow_d;
         cnt_underflow_q <= cnt_underflow_d;
         cnt_drop_q      <= cnt_drop_d;
      end
   end

   assign cnt_exact     = cnt_exact_q;
   assign cnt_overflow  = cnt_overflow_q;
   assign cnt_underflow = cnt_underflow_q;
   assign cnt_drop      = cnt_drop_q;
`endif

endmodule

// File: tb/tb_fpu_result_monitor.sv
// Self-checking bench for fpu_result_monitor: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
// Statistics checks are active when FPU_MON_STATS_EN is defined.
`timescale 1ns/1ps
module tb_fpu_result_monitor;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_in = '0;
   logic [3:0]  status_in = '0;
   logic        out_ready = 1'b0;
   logic        clear = 1'b0;
   logic        out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_status;
   logic [$clog2(DEPTH):0] fill_level;
   logic        drop_flag;
   logic [CNT_W-1:0] cnt_exact, cnt_overflow, cnt_underflow, cnt_drop;

   int tests_run = 0;
   int tests_failed = 0;

   fpu_result_monitor #(.DEPTH(DEPTH)) dut (
      .clock100KHz (clk),
      .reset       (rst_n),
      .data_in     (data_in),
      .status_in   (status_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_status  (out_status),
      .fill_level  (fill_level),
      .drop_flag   (drop_flag),
      .clear       (clear)
`ifdef FPU_MON_STATS_EN
      ,
      .cnt_exact     (cnt_exact),
      .cnt_overflow  (cnt_overflow),
      .cnt_underflow (cnt_underflow),
      .cnt_drop      (cnt_drop)
`endif
   );

`ifndef FPU_MON_STATS_EN
   assign cnt_exact = '0;
   assign cnt_overflow = '0;
   assign cnt_underflow = '0;
   assign cnt_drop = '0;
`endif

   always #5000 clk = ~clk;  // 100 kHz

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [35:0] mq[$];
   logic [35:0] m_last, m_lastpop, m_w;
   bit          m_drop, m_nr, m_pop, m_acc;
   int          m_ex, m_ov, m_un, m_dr;

   function automatic int sat_inc(input int v);
      return (v == (1 << CNT_W) - 1) ? v : v + 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_last = '0; m_lastpop = '0; m_drop = 0;
         m_ex = 0; m_ov = 0; m_un = 0; m_dr = 0;
      end else begin
         m_w   = {status_in, data_in};
         m_nr  = (status_in != 4'd0) && (m_w != m_last);
         m_pop = (mq.size() != 0) && out_ready;
         m_acc = m_nr && ((mq.size() < DEPTH) || m_pop);
         if (m_nr) m_last = m_w;
         if (m_pop) m_lastpop = mq.pop_front();
         if (m_acc) mq.push_back(m_w);
         if (m_nr && !m_acc) m_drop = 1;
         else if (clear) m_drop = 0;
         if (clear) begin m_ex = 0; m_ov = 0; m_un = 0; m_dr = 0; end
         if (m_nr && status_in == 4'b0001) m_ex = sat_inc(m_ex);
         if (m_nr && status_in == 4'b0100) m_ov = sat_inc(m_ov);
         if (m_nr && status_in == 4'b1000) m_un = sat_inc(m_un);
         if (m_nr && !m_acc) m_dr = sat_inc(m_dr);
      end
   end

   // Compare process: outputs checked against the model on every falling edge.
   always @(negedge clk) begin
      logic [35:0] head;
      head = (mq.size() != 0) ? mq[0] : m_lastpop;
      check("model out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("model fill_level", 64'(fill_level), 64'(mq.size()));
      check("model out_data", 64'(out_data), 64'(head[31:0]));
      check("model out_status", 64'(out_status), 64'(head[35:32]));
      check("model drop_flag", 64'(drop_flag), 64'(m_drop));
`ifdef FPU_MON_STATS_EN
      check("model cnt_exact", 64'(cnt_exact), 64'(m_ex));
      check("model cnt_overflow", 64'(cnt_overflow), 64'(m_ov));
      check("model cnt_underflow", 64'(cnt_underflow), 64'(m_un));
      check("model cnt_drop", 64'(cnt_drop), 64'(m_dr));
`endif
   end

   // Drive at the falling edge, return just after the next rising edge.
   task automatic step(input logic [3:0] st, input logic [31:0] d,
                       input logic rdy, input logic clr);
      @(negedge clk);
      status_in = st; data_in = d; out_ready = rdy; clear = clr;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset fill_level", 64'(fill_level), 64'd0);
      check("reset out_data", 64'(out_data), 64'd0);
      check("reset out_status", 64'(out_status), 64'd0);
      check("reset drop_flag", 64'(drop_flag), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // status 0 never counts as a result
      repeat (10) step(4'b0000, 32'h1234_5678, 1'b0, 1'b0);
      check("idle out_valid", 64'(out_valid), 64'd0);
      check("idle fill_level", 64'(fill_level), 64'd0);

      // held result collapses into one entry
      repeat (8) step(4'b0001, 32'h4000_0000, 1'b0, 1'b0);
      check("held fill_level", 64'(fill_level), 64'd1);
      check("held out_data", 64'(out_data), 64'h4000_0000);
      check("held out_status", 64'(out_status), 64'h1);
      step(4'b0001, 32'h4000_0000, 1'b1, 1'b0);
      check("drain fill_level", 64'(fill_level), 64'd0);
      check("drain out_valid", 64'(out_valid), 64'd0);
      check("empty holds last", 64'(out_data), 64'h4000_0000);
      step(4'b0001, 32'h4000_0000, 1'b1, 1'b0);
      check("ready on empty", 64'(fill_level), 64'd0);

      // fill to DEPTH, then overflow drops
      for (int i = 1; i <= 4; i++) step(4'b0001, 32'h0100_0000 + i, 1'b0, 1'b0);
      check("full fill_level", 64'(fill_level), 64'd4);
      check("full no drop yet", 64'(drop_flag), 64'd0);
      step(4'b0100, 32'h7E00_0000, 1'b0, 1'b0);
      check("overrun fill_level", 64'(fill_level), 64'd4);
      check("overrun drop_flag", 64'(drop_flag), 64'd1);
`ifdef FPU_MON_STATS_EN
      check("overrun cnt_drop", 64'(cnt_drop), 64'd1);
      check("overrun cnt_overflow", 64'(cnt_overflow), 64'd1);
      check("overrun cnt_exact", 64'(cnt_exact), 64'd5);
`endif
      // clear and a new drop in the same cycle: drop wins
      step(4'b0100, 32'h7E00_0001, 1'b0, 1'b1);
      check("clear+drop drop_flag", 64'(drop_flag), 64'd1);
`ifdef FPU_MON_STATS_EN
      check("clear+drop cnt_drop", 64'(cnt_drop), 64'd1);
      check("clear+drop cnt_exact", 64'(cnt_exact), 64'd0);
`endif
      for (int i = 1; i <= 4; i++) begin
         check("pop order", 64'(out_data), 64'(32'h0100_0000 + i));
         step(4'b0100, 32'h7E00_0001, 1'b1, 1'b0);
      end
      check("popped fill_level", 64'(fill_level), 64'd0);
      step(4'b0100, 32'h7E00_0001, 1'b0, 1'b1);
      check("clear drop_flag", 64'(drop_flag), 64'd0);

      // full FIFO with same-cycle pop accepts the push
      for (int i = 1; i <= 4; i++) step(4'b0001, 32'h0200_0000 + i, 1'b0, 1'b0);
      step(4'b0001, 32'h0000_0005, 1'b1, 1'b0);
      check("push+pop fill_level", 64'(fill_level), 64'd4);
      check("push+pop drop_flag", 64'(drop_flag), 64'd0);
      check("push+pop head", 64'(out_data), 64'h0200_0002);
      repeat (4) step(4'b0001, 32'h0000_0005, 1'b1, 1'b0);
      check("tail drained", 64'(fill_level), 64'd0);
      check("tail value", 64'(out_data), 64'h0000_0005);

      // same word, different status -> two entries
      step(4'b0001, 32'h3F00_0000, 1'b0, 1'b0);
      step(4'b1000, 32'h3F00_0000, 1'b0, 1'b0);
      check("status diff fill", 64'(fill_level), 64'd2);
      check("status diff head", 64'(out_status), 64'h1);
`ifdef FPU_MON_STATS_EN
      check("cnt_underflow", 64'(cnt_underflow), 64'd1);
`endif

      // asynchronous reset mid-cycle
      @(negedge clk);
      #100;
      status_in = 4'b0001; data_in = 32'h3F00_0000; out_ready = 1'b0; clear = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst fill_level", 64'(fill_level), 64'd0);
      @(negedge clk);
      #100;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("recapture fill", 64'(fill_level), 64'd1);
      check("recapture data", 64'(out_data), 64'h3F00_0000);
      check("recapture status", 64'(out_status), 64'h1);

      repeat (2) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
